// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over req/ack and buffers
// {instr, pc} in a show-ahead FIFO for decode. Optional FETCH_PERF_CNT_EN adds instr_count_o.
module fetch_unit #(
  parameter int                      ARCHITECTURE = 32,
  parameter int                      FIFO_DEPTH   = 4,
  parameter logic [ARCHITECTURE-1:0] RESET_PC     = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    redirect_valid_i,
  input  logic [ARCHITECTURE-1:0] redirect_pc_i,
  output logic                    imem_req_o,
  output logic [ARCHITECTURE-1:0] imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [ARCHITECTURE-1:0] imem_rdata_i,
  output logic                    instr_valid_o,
  output logic [ARCHITECTURE-1:0] instr_o,
  output logic [ARCHITECTURE-1:0] instr_pc_o,
  input  logic                    instr_ready_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]             instr_count_o
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]           DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ARCHITECTURE-1:0] PC_STEP = ARCHITECTURE'(4);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ARCHITECTURE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ARCHITECTURE-1:0] addr_q, addr_d;

  logic [ARCHITECTURE-1:0] mem_instr [FIFO_DEPTH];
  logic [ARCHITECTURE-1:0] mem_pc    [FIFO_DEPTH];
  logic [PW-1:0]           rd_ptr_q, wr_ptr_q, rd_next;
  logic [CW-1:0]           count_q;
  logic [ARCHITECTURE-1:0] head_instr_q, head_pc_q;

  logic push, pop, flush;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];
  assign rd_next        = rd_ptr_q + PW'(1);

  // Handshakes: imem request completes in any cycle with imem_req_o && imem_ack_i; the
  // FIFO head transfers to decode in any cycle with instr_valid_o && instr_ready_i, except
  // that a redirect in that cycle wins and the head is flushed rather than consumed.
  assign flush = redirect_valid_i;
  assign pop   = (count_q != '0) && instr_ready_i && !flush;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Issue only when a slot is free; that slot stays reserved for the returning word.
        if (!flush && (count_q < DEPTH_C)) begin
          state_d = S_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (imem_ack_i) begin
          state_d = S_IDLE;
          if (!flush) begin
            push       = 1'b1;
            fetch_pc_d = addr_q + PC_STEP;
          end
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) fetch_pc_d = {redirect_pc_i[ARCHITECTURE-1:2], 2'b00};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= imem_rdata_i;
      mem_pc[wr_ptr_q]    <= addr_q;
    end
  end

  // Head registers are loaded with whatever entry will be at the front next cycle, so
  // they hold their last value once the FIFO drains or is flushed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
    end else if (flush) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_next;
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push && ((count_q == '0) || (pop && (count_q == CW'(1))))) begin
        head_instr_q <= imem_rdata_i;
        head_pc_q    <= addr_q;
      end else if (pop && (count_q > CW'(1))) begin
        head_instr_q <= mem_instr[rd_next];
        head_pc_q    <= mem_pc[rd_next];
      end
    end
  end

  assign imem_req_o    = (state_q != S_IDLE);
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = head_instr_q;
  assign instr_pc_o    = head_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)    perf_cnt_q <= '0;
    else if (pop) perf_cnt_q <= perf_cnt_q + 32'd1;
  end

  assign instr_count_o = perf_cnt_q;
`endif

endmodule
